axi_ic_resp_arbiter: RTL and testbench

Response-path arbiter of the AXI interconnect: for every master port it selects which slave's read-data or write-response stream is forwarded back, mirroring the per-slave address-channel arbiter. Slave responses carry a destination master index, taken from the upper ID bits. Per master, contending slaves are served round-robin, and a selected stream is held until its burst completes. Zero-latency selection sits between the slave response muxes and the master response ports.

---
 rtl/ic_pkg.sv | 34 +++
 rtl/axi_ic_resp_arb_slice.sv | 73 +++++++
 rtl/axi_ic_resp_arbiter.sv | 69 ++++++
 tb/tb_axi_ic_resp_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ic_pkg.sv
// Shared interconnect definitions: port-count defaults, arbiter state type and
// one-hot helpers used by both the address and response arbiters.
package ic_pkg;

  localparam int MSTRNUM_DEF = 4;
  localparam int SLVNUM_DEF  = 4;

  // Widest one-hot vector the rotate helper handles; port counts must not exceed it.
  localparam int ONEHOT_MAXW = 64;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

  // Rotate a one-hot vector of width w left by one position, wrapping the top bit to bit 0.
  function automatic logic [ONEHOT_MAXW-1:0] onehot_rotl1(
    input logic [ONEHOT_MAXW-1:0] v,
    input int                     w
  );
    logic [ONEHOT_MAXW-1:0] mask;
    mask = (w >= ONEHOT_MAXW) ? '1 : ((ONEHOT_MAXW'(1) << w) - ONEHOT_MAXW'(1));
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/axi_ic_resp_arb_slice.sv
// One master's response arbiter: round-robin pick among candidate slaves, locked
// until the selected burst's LAST beat is accepted.
module axi_ic_resp_arb_slice
  import ic_pkg::*;
#(
  parameter int SLVNUM = SLVNUM_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SLVNUM-1:0] i_cand,
  input  logic [SLVNUM-1:0] i_valid,
  input  logic [SLVNUM-1:0] i_last,
  input  logic              i_ready,
  output logic [SLVNUM-1:0] o_sel,
  output logic              o_valid,
  output logic              o_busy,
  output logic [SLVNUM-1:0] o_prio
);

  arb_state_e        r_state;
  logic [SLVNUM-1:0] r_sel_q;
  logic [SLVNUM-1:0] r_prio_q;

  logic [SLVNUM-1:0] w_hi;
  logic [SLVNUM-1:0] w_pick;
  logic [SLVNUM-1:0] w_arb;
  logic              w_valid;
  logic              w_done;

  // Candidates at or above the priority slave win first; otherwise wrap to the lowest one.
  assign w_hi   = i_cand & ~(r_prio_q - SLVNUM'(1));
  assign w_pick = (|w_hi) ? (w_hi & (~w_hi + SLVNUM'(1)))
                          : (i_cand & (~i_cand + SLVNUM'(1)));

  assign w_arb   = (r_state == ARB_BUSY) ? r_sel_q : w_pick;
  assign w_valid = (r_state == ARB_BUSY) ? |(r_sel_q & i_valid) : |w_pick;
  assign w_done  = w_valid & i_ready & |(w_arb & i_last);

  // Nothing is forwarded while reset is held, even though the pick logic is combinational.
  assign o_sel   = reset ? '0 : w_arb;
  assign o_valid = w_valid & ~reset;
  assign o_busy  = (r_state == ARB_BUSY);
  assign o_prio  = r_prio_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ARB_IDLE;
      r_sel_q  <= '0;
      r_prio_q <= SLVNUM'(1);
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (|w_pick && !w_done) begin
            r_state <= ARB_BUSY;
            r_sel_q <= w_pick;
          end
        end
        ARB_BUSY: begin
          if (w_done) begin
            r_state <= ARB_IDLE;
            r_sel_q <= '0;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_sel_q <= '0;
        end
      endcase
      if (w_done) r_prio_q <= SLVNUM'(onehot_rotl1(ONEHOT_MAXW'(w_arb), SLVNUM));
    end
  end

endmodule

// File: rtl/axi_ic_resp_arbiter.sv
// Response-path arbiter: decodes each slave's destination master, runs one
// arbitration slice per master and merges the per-master grants into slave READY.
module axi_ic_resp_arbiter
  import ic_pkg::*;
#(
  parameter int MSTRNUM = MSTRNUM_DEF,
  parameter int SLVNUM  = SLVNUM_DEF,
  parameter int MIDW    = clog2(MSTRNUM)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SLVNUM-1:0]         s_valid,
  input  logic [SLVNUM-1:0]         s_last,
  input  logic [SLVNUM*MIDW-1:0]    s_mstr,
  input  logic [MSTRNUM-1:0]        m_ready,
  output logic [MSTRNUM-1:0]        m_valid,
  output logic [MSTRNUM*SLVNUM-1:0] m_sel,
  output logic [SLVNUM-1:0]         s_ready,
  output logic [SLVNUM-1:0]         s_decerr,
  output logic [MSTRNUM-1:0]        dbg_busy,
  output logic [MSTRNUM*SLVNUM-1:0] dbg_prio
);

  // Handshake: a beat moves from slave s to master m when m_valid[m] & m_ready[m]
  // with m_sel[m][s] set; s_ready[s] mirrors that master's READY for the selected slave.

  logic [SLVNUM-1:0][MIDW-1:0]    w_idx;
  logic [MSTRNUM-1:0][SLVNUM-1:0] w_cand;
  logic [MSTRNUM-1:0][SLVNUM-1:0] w_sel;
  logic [MSTRNUM-1:0][SLVNUM-1:0] w_prio;

  for (genvar s = 0; s < SLVNUM; s++) begin : g_slv
    assign w_idx[s]    = s_mstr[s*MIDW +: MIDW];
    assign s_decerr[s] = s_valid[s] & (int'(w_idx[s]) >= MSTRNUM);
  end

  for (genvar m = 0; m < MSTRNUM; m++) begin : g_mst
    for (genvar s = 0; s < SLVNUM; s++) begin : g_cand
      assign w_cand[m][s] = s_valid[s] & (int'(w_idx[s]) == m);
    end

    axi_ic_resp_arb_slice #(
      .SLVNUM (SLVNUM)
    ) u_slice (
      .clk     (clk),
      .reset   (reset),
      .i_cand  (w_cand[m]),
      .i_valid (s_valid),
      .i_last  (s_last),
      .i_ready (m_ready[m]),
      .o_sel   (w_sel[m]),
      .o_valid (m_valid[m]),
      .o_busy  (dbg_busy[m]),
      .o_prio  (w_prio[m])
    );

    assign m_sel[m*SLVNUM +: SLVNUM]    = w_sel[m];
    assign dbg_prio[m*SLVNUM +: SLVNUM] = w_prio[m];
  end

  // A slave targets a single master, so at most one term of this OR is active.
  always_comb begin
    s_ready = '0;
    for (int m = 0; m < MSTRNUM; m++) begin
      s_ready = s_ready | (w_sel[m] & {SLVNUM{m_ready[m]}});
    end
  end

endmodule

// File: tb/tb_axi_ic_resp_arbiter.sv
// Bench for axi_ic_resp_arbiter with three masters (so index 3 is a decode miss)
// and four slaves: directed scenarios followed by randomized traffic.
module tb_axi_ic_resp_arbiter;

  localparam int MN = 3;
  localparam int SN = 4;
  localparam int MW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [SN-1:0]    s_valid, s_last;
  logic [SN*MW-1:0] s_mstr;
  logic [MN-1:0]    m_ready;
  logic [MN-1:0]    m_valid;
  logic [MN*SN-1:0] m_sel;
  logic [SN-1:0]    s_ready, s_decerr;
  logic [MN-1:0]    dbg_busy;
  logic [MN*SN-1:0] dbg_prio;

  always #5 clk = ~clk;

  axi_ic_resp_arbiter #(.MSTRNUM(MN), .SLVNUM(SN), .MIDW(MW)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_mstr   (s_mstr),
    .m_ready  (m_ready),
    .m_valid  (m_valid),
    .m_sel    (m_sel),
    .s_ready  (s_ready),
    .s_decerr (s_decerr),
    .dbg_busy (dbg_busy),
    .dbg_prio (dbg_prio)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [SN-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: per master, the slave currently owning the port (-1 = free)
  // and the index of the slave that has first claim on the next arbitration.
  int owner[MN];
  int nxt[MN];
  int sel_i[MN];
  bit v_e[MN];

  function automatic void model_reset();
    for (int m = 0; m < MN; m++) begin
      owner[m] = -1;
      nxt[m]   = 0;
      sel_i[m] = -1;
      v_e[m]   = 1'b0;
    end
  endfunction

  function automatic void model_eval();
    for (int m = 0; m < MN; m++) begin
      sel_i[m] = -1;
      v_e[m]   = 1'b0;
      if (reset) continue;
      if (owner[m] >= 0) begin
        sel_i[m] = owner[m];
        v_e[m]   = s_valid[owner[m]];
      end else begin
        for (int i = 0; i < SN; i++) begin
          int s;
          s = (nxt[m] + i) % SN;
          if (sel_i[m] < 0 && s_valid[s] && (int'(s_mstr[s*MW +: MW]) == m)) begin
            sel_i[m] = s;
            v_e[m]   = 1'b1;
          end
        end
      end
    end
  endfunction

  function automatic void model_commit();
    if (reset) begin
      model_reset();
      return;
    end
    for (int m = 0; m < MN; m++) begin
      if (sel_i[m] >= 0 && v_e[m] && m_ready[m] && s_last[sel_i[m]]) begin
        owner[m] = -1;
        nxt[m]   = (sel_i[m] + 1) % SN;
      end else if (owner[m] < 0 && sel_i[m] >= 0) begin
        owner[m] = sel_i[m];
      end
    end
  endfunction

  task automatic compare_all();
    logic [MN-1:0]    e_mv, e_bz;
    logic [MN*SN-1:0] e_ms, e_pr;
    logic [SN-1:0]    e_sr, e_de;
    e_mv = '0; e_bz = '0; e_ms = '0; e_pr = '0; e_sr = '0; e_de = '0;
    for (int m = 0; m < MN; m++) begin
      e_mv[m] = v_e[m];
      e_bz[m] = (owner[m] >= 0);
      e_pr[m*SN + nxt[m]] = 1'b1;
      if (sel_i[m] >= 0) begin
        e_ms[m*SN + sel_i[m]] = 1'b1;
        if (m_ready[m]) e_sr[sel_i[m]] = 1'b1;
      end
    end
    for (int s = 0; s < SN; s++) e_de[s] = s_valid[s] && (int'(s_mstr[s*MW +: MW]) >= MN);
    check_eq("m_valid", 32'(m_valid), 32'(e_mv));
    check_eq("m_sel", 32'(m_sel), 32'(e_ms));
    check_eq("s_ready", 32'(s_ready), 32'(e_sr));
    check_eq("s_decerr", 32'(s_decerr), 32'(e_de));
    check_eq("busy", 32'(dbg_busy), 32'(e_bz));
    check_eq("prio", 32'(dbg_prio), 32'(e_pr));
  endtask

  task automatic settle_check();
    @(negedge clk);
    model_eval();
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic cycle();
    settle_check();
    tick();
  endtask

  task automatic clear_in();
    s_valid = '0;
    s_last  = '0;
    s_mstr  = '0;
    m_ready = '0;
  endtask

  task automatic set_slv(input int s, input logic v, input logic l, input int m);
    s_valid[s] = v;
    s_last[s]  = l;
    s_mstr[s*MW +: MW] = MW'(m);
  endtask

  initial begin
    logic [SN-1:0] hs;
    reset = 1'b1;
    clear_in();
    model_reset();
    cycle();
    check_eq("rst_prio", 32'(dbg_prio), 32'h111);
    check_eq("rst_sel", 32'(m_sel), 32'h0);
    cycle();
    reset = 1'b0;

    // Four-beat burst from slave 0 to master 1.
    m_ready = '1;
    set_slv(0, 1'b1, 1'b0, 1);
    for (int b = 0; b < 4; b++) begin
      s_last[0] = (b == 3);
      settle_check();
      check_eq("t1_sel", 32'(m_sel[1*SN +: SN]), 32'h1);
      tick();
      if (b == 0) check_eq("t1_busy", 32'(dbg_busy[1]), 32'h1);
    end
    check_eq("t1_idle", 32'(dbg_busy[1]), 32'h0);
    check_eq("t1_prio", 32'(dbg_prio[1*SN +: SN]), 32'h2);
    clear_in();
    cycle();

    // Slaves 0 and 2 contend for master 0; grant order via the expected queue.
    m_ready = '1;
    set_slv(0, 1'b1, 1'b1, 0);
    set_slv(2, 1'b1, 1'b1, 0);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0100);
    for (int c = 0; c < 4; c++) begin
      settle_check();
      hs = '0;
      if (m_valid[0] && m_ready[0] && exp_q.size() > 0) begin
        hs = m_sel[0 +: SN];
        check_eq("t2_order", 32'(hs), 32'(exp_q.pop_front()));
      end
      tick();
      s_valid = s_valid & ~hs;
    end
    check_eq("t2_drain", exp_q.size(), 0);
    check_eq("t2_prio", 32'(dbg_prio[0 +: SN]), 32'h8);
    clear_in();
    cycle();

    // Master 0 stalled while holding slave 0; slave 1 must wait.
    set_slv(0, 1'b1, 1'b0, 0);
    set_slv(1, 1'b1, 1'b1, 0);
    for (int c = 0; c < 3; c++) begin
      settle_check();
      check_eq("t3_sel", 32'(m_sel[0 +: SN]), 32'h1);
      check_eq("t3_srdy1", 32'(s_ready[1]), 32'h0);
      tick();
    end
    m_ready[0] = 1'b1;
    s_last[0]  = 1'b1;
    settle_check();
    check_eq("t3_srdy", 32'(s_ready), 32'h1);
    tick();
    s_valid[0] = 1'b0;
    settle_check();
    check_eq("t3_next", 32'(m_sel[0 +: SN]), 32'h2);
    tick();
    clear_in();
    cycle();

    // Two masters served in the same cycle.
    m_ready = '1;
    set_slv(0, 1'b1, 1'b1, 0);
    set_slv(1, 1'b1, 1'b1, 1);
    settle_check();
    check_eq("t4_srdy", 32'(s_ready), 32'h3);
    check_eq("t4_mvalid", 32'(m_valid), 32'h3);
    tick();
    clear_in();
    cycle();

    // Decode miss on slave 3.
    m_ready = '1;
    set_slv(3, 1'b1, 1'b1, 3);
    settle_check();
    check_eq("t5_decerr", 32'(s_decerr), 32'h8);
    check_eq("t5_srdy3", 32'(s_ready[3]), 32'h0);
    check_eq("t5_mvalid", 32'(m_valid), 32'h0);
    tick();
    clear_in();
    cycle();

    // Reset mid-burst on master 1.
    m_ready = '1;
    set_slv(0, 1'b1, 1'b0, 1);
    cycle();
    reset = 1'b1;
    model_reset();
    settle_check();
    check_eq("t6_mvalid", 32'(m_valid), 32'h0);
    check_eq("t6_sel", 32'(m_sel[1*SN +: SN]), 32'h0);
    tick();
    reset = 1'b0;
    check_eq("t6_prio", 32'(dbg_prio[1*SN +: SN]), 32'h1);
    settle_check();
    check_eq("t6_idle", 32'(dbg_busy[1]), 32'h0);
    check_eq("t6_rearb", 32'(m_sel[1*SN +: SN]), 32'h1);
    tick();
    s_last[0] = 1'b1;
    cycle();
    clear_in();
    cycle();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      for (int s = 0; s < SN; s++) begin
        s_valid[s] = ($urandom_range(0, 3) != 0);
        s_last[s]  = ($urandom_range(0, 2) == 0);
        s_mstr[s*MW +: MW] = MW'($urandom_range(0, 3));
      end
      for (int m = 0; m < MN; m++) m_ready[m] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        model_reset();
        cycle();
        reset = 1'b0;
      end else begin
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
